// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the SDRAM command-port arbiter.
// Contents: FSM state enumeration and the owner codes driven on the owner port.
// No ports; imported by sdram_port_arb.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RD   = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;

endpackage

// File: rtl/arb_done_timer.sv
// arb_done_timer: saturating burst-completion watchdog counter.
// Ports: i_clr restarts the count at 0, i_en advances it by one per cycle,
//        o_expired is high while the count sits at TIMEOUT_CYC-1 (TIMEOUT_CYC >= 2).
module arb_done_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at CNT_MAX instead of wrapping so a stuck burst stays expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CNT_MAX);

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: grants the single SDRAM command port to the TFT reader (rd_*)
// or the UART frame loader (wr_*), issues the registered burst command
// (sd_cmd_*) and tracks it to sd_done or timeout (err). owner reports the holder.
// Build option: define ARB_STARVE_GUARD_EN to let a waiting write win after
// STARVE_MAX consecutive read grants; otherwise reads have strict priority.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int LEN_W       = 9,
  parameter int TIMEOUT_CYC = 4096,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              sd_cmd_valid,
  input  logic              sd_cmd_ready,
  output logic              sd_cmd_wr,
  output logic [ADDR_W-1:0] sd_cmd_addr,
  output logic [LEN_W-1:0]  sd_cmd_len,
  input  logic              sd_done,
  output logic [1:0]        owner,
  output logic              err
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_cmd_wr, w_cmd_wr_nxt;
  logic [ADDR_W-1:0] r_cmd_addr, w_cmd_addr_nxt;
  logic [LEN_W-1:0]  r_cmd_len, w_cmd_len_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic              r_rd_gnt, w_rd_gnt_nxt;
  logic              r_wr_gnt, w_wr_gnt_nxt;
  logic              r_rd_done, w_rd_done_nxt;
  logic              r_wr_done, w_wr_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_accept;
  logic              w_expired;
  logic              w_force_wr;

  assign w_accept = (r_state == ISSUE) && sd_cmd_ready;

  // Timer restarts on command accept, so time spent waiting in ISSUE is not charged.
  arb_done_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept),
    .i_en      (r_state == WAIT_DONE),
    .o_expired (w_expired)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] r_starve_cnt;

  // Counts reads that jumped a pending write; never exceeds STARVE_MAX because
  // reaching it forces the next contested grant to the write, which clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_wr_gnt_nxt) begin
      r_starve_cnt <= '0;
    end else if ((r_state == IDLE) && !wr_req) begin
      r_starve_cnt <= '0;
    end else if (w_rd_gnt_nxt && wr_req) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_force_wr = (r_starve_cnt == SC_W'(STARVE_MAX));
`else
  logic w_unused_starve;
  assign w_unused_starve = |STARVE_MAX;
  assign w_force_wr      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cmd_wr   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
      r_owner    <= OWN_NONE;
      r_rd_gnt   <= 1'b0;
      r_wr_gnt   <= 1'b0;
      r_rd_done  <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_wr   <= w_cmd_wr_nxt;
      r_cmd_addr <= w_cmd_addr_nxt;
      r_cmd_len  <= w_cmd_len_nxt;
      r_owner    <= w_owner_nxt;
      r_rd_gnt   <= w_rd_gnt_nxt;
      r_wr_gnt   <= w_wr_gnt_nxt;
      r_rd_done  <= w_rd_done_nxt;
      r_wr_done  <= w_wr_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_wr_nxt   = r_cmd_wr;
    w_cmd_addr_nxt = r_cmd_addr;
    w_cmd_len_nxt  = r_cmd_len;
    w_owner_nxt    = r_owner;
    w_rd_gnt_nxt   = 1'b0;
    w_wr_gnt_nxt   = 1'b0;
    w_rd_done_nxt  = 1'b0;
    w_wr_done_nxt  = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_req && !(wr_req && w_force_wr)) begin
          w_cmd_wr_nxt   = 1'b0;
          w_cmd_addr_nxt = rd_addr;
          w_cmd_len_nxt  = rd_len;
          w_owner_nxt    = OWN_RD;
          w_rd_gnt_nxt   = 1'b1;
          w_state_nxt    = ISSUE;
        end else if (wr_req) begin
          w_cmd_wr_nxt   = 1'b1;
          w_cmd_addr_nxt = wr_addr;
          w_cmd_len_nxt  = wr_len;
          w_owner_nxt    = OWN_WR;
          w_wr_gnt_nxt   = 1'b1;
          w_state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (sd_cmd_ready) begin
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A real sd_done wins over an expiry in the same cycle.
        if (sd_done || w_expired) begin
          w_rd_done_nxt = (r_owner == OWN_RD);
          w_wr_done_nxt = (r_owner == OWN_WR);
          w_err_nxt     = !sd_done;
          w_owner_nxt   = OWN_NONE;
          w_state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign sd_cmd_valid = (r_state == ISSUE);
  assign sd_cmd_wr    = r_cmd_wr;
  assign sd_cmd_addr  = r_cmd_addr;
  assign sd_cmd_len   = r_cmd_len;
  assign owner        = r_owner;
  assign rd_gnt       = r_rd_gnt;
  assign wr_gnt       = r_wr_gnt;
  assign rd_done      = r_rd_done;
  assign wr_done      = r_wr_done;
  assign err          = r_err;

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Two-requester arbiter for the single SDRAM controller command port. The TFT refresh reader (line prefetch) and the UART frame loader (pixel writer fed by the UART command parser) each request bursts. The block grants one at a time, issues the burst command to the SDRAM controller and tracks it to completion. A done-timeout supervises every burst, and an optional starvation guard bounds how long a pending write can be blocked by reads.

## Interface
Parameters:
- ADDR_W, 22, SDRAM word address width
- LEN_W, 9, burst length field width; value encodes words−1
- TIMEOUT_CYC, 4096, max cycles from command accept to sd_done
- STARVE_MAX, 4, consecutive read grants tolerated while wr_req is pending (guard build only)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_req  in  1  TFT read burst request; level, held until rd_gnt
- rd_addr  in  ADDR_W  read start address; stable while rd_req high
- rd_len  in  LEN_W  read burst words−1
- rd_gnt  out  1  one-cycle pulse, read command being issued
- rd_done  out  1  one-cycle pulse, read burst finished
- wr_req, wr_addr, wr_len, wr_gnt, wr_done  same as rd_*, write side
- sd_cmd_valid  out  1  command valid to SDRAM controller
- sd_cmd_ready  in  1  controller accepts command when valid&ready
- sd_cmd_wr  out  1  1 = write, 0 = read
- sd_cmd_addr  out  ADDR_W  registered command address
- sd_cmd_len  out  LEN_W  registered command length
- sd_done  in  1  controller pulse, burst complete
- owner  out  2  0 = none, 1 = read, 2 = write
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE:
  - samples rd_req/wr_req.
  - Neither → stay.
  - One → grant it.
  - Both → read wins, except when the guard forces the write.
  - On grant: latch addr/len/direction into sd_cmd_*, pulse *_gnt, set owner, go ISSUE.
- ISSUE:
  - sd_cmd_valid=1; sd_cmd_* held constant.
  - valid&ready → go WAIT_DONE, clear timer.
  - Requests are not re-sampled while in ISSUE.
- WAIT_DONE:
  - timer counts up.
  - sd_done → pulse rd_done or wr_done, go RELEASE.
  - Timer reaches TIMEOUT_CYC−1 without sd_done → pulse err and the owner's *_done together, go RELEASE.
  - sd_done on the same cycle as the timeout edge counts as a normal completion: no err.
- RELEASE:
  - owner=0, one dead cycle, then IDLE.
  - Guarantees the requester sees done before its next req is sampled.
- sd_done outside WAIT_DONE is ignored.
- A requester dropping req before its grant is simply not granted; no pulses.
- Reset (any state): state=IDLE, owner=0, sd_cmd_valid=0, sd_cmd_wr=0, sd_cmd_addr=0, sd_cmd_len=0, all *_gnt/*_done/err=0, timer and starve counter=0.

## Timing
- Grant latency: req high in IDLE at cycle N → *_gnt and sd_cmd_valid at N+1.
- Best case with sd_cmd_ready already high: accept at N+1, WAIT_DONE from N+2.
- Done latency: sd_done at cycle M → *_done at M+1, RELEASE at M+1, IDLE at M+2, earliest next grant M+3.
- Timer is $clog2(TIMEOUT_CYC) bits and saturates; it never wraps.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each read grant issued while wr_req=1.
  - It clears on any write grant, and clears when wr_req=0 in IDLE.
  - When the counter equals STARVE_MAX and both requests are present, the write is granted.
- Not defined: strict read priority, no counter logic. STARVE_MAX is unused.

## Structure
- Shared package sdram_arb_pkg holds:
  - the state enumeration (IDLE=0, ISSUE=1, WAIT_DONE=2, RELEASE=3)
  - owner codes OWN_NONE/OWN_RD/OWN_WR
- One sub-module, arb_done_timer: load/clear, enable, saturating count, expiry flag.
- Everything else lives in the top FSM.

## Test plan
- rd_req only, addr=0x00100, len=319, sd_cmd_ready=1, sd_done 400 cycles after accept → rd_gnt at +1, sd_cmd_wr=0, addr 0x00100, len 319, rd_done one cycle after sd_done, owner back to 0.
- rd_req and wr_req high together, guard off → read granted first; write granted 3 cycles after the read's sd_done.
- Guard on, STARVE_MAX=4, rd_req held high, wr_req held high → 4 read grants, then the 5th grant goes to the write.
- sd_cmd_ready held low for 50 cycles → sd_cmd_valid and sd_cmd_addr stay constant for all 50 cycles; accepted on cycle 51; no timeout counted during ISSUE.
- TIMEOUT_CYC=16, sd_done never arrives → err and wr_done pulse together 16 cycles after accept; next request then served normally.
- rst asserted mid-WAIT_DONE → outputs clear immediately (async); a late sd_done after rst release produces no *_done.
